// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline hazard bus between the decode/issue logic and the scoreboard:
// stage destinations and sources in, forwarding selects and stall controls out.
interface hazard_scoreboard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 4
);
  localparam int NUM_REGS = 2**REG_ADDR_W;

  logic                  RegWrite_MEM;
  logic                  RegWrite_WB;
  logic [REG_ADDR_W-1:0] rd_MEM;
  logic [REG_ADDR_W-1:0] rd_WB;
  logic [REG_ADDR_W-1:0] rd_EX;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic                  rs1_used;
  logic                  rs2_used;
  logic                  MemRead_EX;
  logic                  lat_issue;
  logic [REG_ADDR_W-1:0] lat_rd;
  logic [LAT_W-1:0]      lat_cycles;
  logic [1:0]            forwardA;
  logic [1:0]            forwardB;
  logic                  stall;
  logic                  flush_EX;
  logic [NUM_REGS-1:0]   pending_mask;
  logic [31:0]           stall_count;

  modport master (
    output RegWrite_MEM, RegWrite_WB, rd_MEM, rd_WB, rd_EX,
           rs1, rs2, rs1_used, rs2_used, MemRead_EX,
           lat_issue, lat_rd, lat_cycles,
    input  forwardA, forwardB, stall, flush_EX, pending_mask, stall_count
  );

  modport slave (
    input  RegWrite_MEM, RegWrite_WB, rd_MEM, rd_WB, rd_EX,
           rs1, rs2, rs1_used, rs2_used, MemRead_EX,
           lat_issue, lat_rd, lat_cycles,
    output forwardA, forwardB, stall, flush_EX, pending_mask, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Forwarding, load-use detection and per-register long-latency scoreboard.
// Define HAZARD_PERF_EN to build the saturating stall-cycle counter.
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  hazard_scoreboard_unit_if.slave bus
);

  localparam int NUM_REGS = 2**REG_ADDR_W;

  logic [LAT_W-1:0] cnt_q [NUM_REGS];
  logic [LAT_W-1:0] cnt_d [NUM_REGS];

  logic load_use;
  logic raw;
  logic waw;
  logic lat_busy;
  logic accept;
  logic stall_int;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  function automatic logic [1:0] fwd_sel(
    input logic                  used,
    input logic [REG_ADDR_W-1:0] src,
    input logic                  wr_mem,
    input logic [REG_ADDR_W-1:0] rd_mem,
    input logic                  wr_wb,
    input logic [REG_ADDR_W-1:0] rd_wb
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (used && wr_mem && (rd_mem == src) && (rd_mem != '0))
      sel = 2'b10;
    else if (used && wr_wb && (rd_wb == src) && (rd_wb != '0))
      sel = 2'b01;
    return sel;
  endfunction

  function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v);
    return (v == '0) ? '0 : v - LAT_W'(1);
  endfunction

  // Combinational hazard detection on the current scoreboard state
  always_comb begin
    fwd_a = fwd_sel(bus.rs1_used, bus.rs1, bus.RegWrite_MEM, bus.rd_MEM,
                    bus.RegWrite_WB, bus.rd_WB);
    fwd_b = fwd_sel(bus.rs2_used, bus.rs2, bus.RegWrite_MEM, bus.rd_MEM,
                    bus.RegWrite_WB, bus.rd_WB);

    load_use = bus.MemRead_EX && (bus.rd_EX != '0) &&
               ((bus.rs1_used && (bus.rs1 == bus.rd_EX)) ||
                (bus.rs2_used && (bus.rs2 == bus.rd_EX)));

    // cnt_q[0] is never loaded, so register 0 can never raise raw
    raw = (bus.rs1_used && (cnt_q[bus.rs1] != '0)) ||
          (bus.rs2_used && (cnt_q[bus.rs2] != '0));

    lat_busy  = (cnt_q[bus.lat_rd] != '0);
    waw       = bus.lat_issue && (bus.lat_rd != '0) && lat_busy;
    accept    = bus.lat_issue && (bus.lat_rd != '0) &&
                (bus.lat_cycles != '0) && !lat_busy;
    stall_int = load_use || raw || waw;
  end

  // Next-state scoreboard: a load wins over the decrement for its own entry
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = sat_dec(cnt_q[r]);
      if (accept && (bus.lat_rd == REG_ADDR_W'(r)))
        cnt_d[r] = bus.lat_cycles;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    bus.pending_mask = '0;
    for (int r = 0; r < NUM_REGS; r++)
      bus.pending_mask[r] = (cnt_q[r] != '0);
  end

  // Reset forces the combinational controls quiet independent of the inputs
  assign bus.forwardA = reset ? fwd_a : 2'b00;
  assign bus.forwardB = reset ? fwd_b : 2'b00;
  assign bus.stall    = reset & stall_int;
  assign bus.flush_EX = reset & stall_int;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt_q <= '0;
    else
      stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_count = stall_cnt_q;
`else
  assign bus.stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed-vector bench for hazard_scoreboard_unit; expected stall_count
// follows whether HAZARD_PERF_EN is defined for the build.
module tb_hazard_scoreboard_unit;

  localparam int REG_ADDR_W = 5;
  localparam int LAT_W      = 4;

`ifdef HAZARD_PERF_EN
  localparam logic [31:0] EXP_SC = 32'd6;
`else
  localparam logic [31:0] EXP_SC = 32'd0;
`endif

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  hazard_scoreboard_unit_if #(.REG_ADDR_W(REG_ADDR_W), .LAT_W(LAT_W)) bus ();

  hazard_scoreboard_unit #(.REG_ADDR_W(REG_ADDR_W), .LAT_W(LAT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.RegWrite_MEM = 1'b0;
    bus.RegWrite_WB  = 1'b0;
    bus.rd_MEM       = '0;
    bus.rd_WB        = '0;
    bus.rd_EX        = '0;
    bus.rs1          = '0;
    bus.rs2          = '0;
    bus.rs1_used     = 1'b0;
    bus.rs2_used     = 1'b0;
    bus.MemRead_EX   = 1'b0;
    bus.lat_issue    = 1'b0;
    bus.lat_rd       = '0;
    bus.lat_cycles   = '0;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b0;
    clear_inputs();

    // In reset: active hazard inputs must not reach the outputs
    bus.RegWrite_MEM = 1'b1; bus.rd_MEM = 5'd5;
    bus.rs1 = 5'd5; bus.rs1_used = 1'b1;
    bus.MemRead_EX = 1'b1; bus.rd_EX = 5'd5;
    tick();
    tick();
    check_vec("rst_fwdA",    64'(bus.forwardA), 64'd0);
    check_vec("rst_stall",   64'(bus.stall), 64'd0);
    check_vec("rst_flush",   64'(bus.flush_EX), 64'd0);
    check_vec("rst_pending", 64'(bus.pending_mask), 64'd0);
    check_vec("rst_scount",  64'(bus.stall_count), 64'd0);

    reset = 1'b1;
    clear_inputs();
    tick();

    // Forwarding priority and register-0 exclusion
    bus.RegWrite_MEM = 1'b1; bus.rd_MEM = 5'd5;
    bus.RegWrite_WB  = 1'b1; bus.rd_WB  = 5'd5;
    bus.rs1 = 5'd5; bus.rs1_used = 1'b1;
    #1 check_vec("fwdA_mem", 64'(bus.forwardA), 64'd2);
    bus.rd_MEM = 5'd0;
    #1 check_vec("fwdA_wb", 64'(bus.forwardA), 64'd1);
    bus.rs1_used = 1'b0;
    #1 check_vec("fwdA_unused", 64'(bus.forwardA), 64'd0);
    bus.rd_MEM = 5'd5; bus.rs2 = 5'd5; bus.rs2_used = 1'b1;
    #1 check_vec("fwdB_mem", 64'(bus.forwardB), 64'd2);
    bus.RegWrite_MEM = 1'b0;
    #1 check_vec("fwdB_wb", 64'(bus.forwardB), 64'd1);
    bus.RegWrite_MEM = 1'b1; bus.rd_MEM = 5'd0; bus.rd_WB = 5'd0;
    bus.rs1 = 5'd0; bus.rs1_used = 1'b1; bus.rs2 = 5'd0;
    #1 check_vec("fwd_r0", {62'd0, bus.forwardA} | {60'd0, bus.forwardB, 2'b00}, 64'd0);
    clear_inputs();

    // Load-use
    bus.MemRead_EX = 1'b1; bus.rd_EX = 5'd7; bus.rs2 = 5'd7; bus.rs2_used = 1'b1;
    #1 check_vec("lu_stall", 64'(bus.stall), 64'd1);
    check_vec("lu_flush", 64'(bus.flush_EX), 64'd1);
    bus.rs2_used = 1'b0;
    #1 check_vec("lu_unused", 64'(bus.stall), 64'd0);
    bus.rd_EX = 5'd0; bus.rs2 = 5'd0; bus.rs2_used = 1'b1;
    #1 check_vec("lu_r0", 64'(bus.stall), 64'd0);
    clear_inputs();
    tick();

    // Long-latency issue to r9 for 3 cycles with a dependent reader
    bus.lat_issue = 1'b1; bus.lat_rd = 5'd9; bus.lat_cycles = 4'd3;
    bus.rs1 = 5'd9; bus.rs1_used = 1'b1;
    #1 check_vec("lat_pre_stall", 64'(bus.stall), 64'd0);
    tick();
    bus.lat_issue = 1'b0;
    #1 check_vec("lat_pend", 64'(bus.pending_mask), 64'h200);
    for (int i = 0; i < 3; i++) begin
      check_vec($sformatf("lat_stall%0d", i), 64'(bus.stall), 64'd1);
      tick();
    end
    check_vec("lat_done_stall", 64'(bus.stall), 64'd0);
    check_vec("lat_done_pend", 64'(bus.pending_mask), 64'd0);
    clear_inputs();

    // WAW: re-issue to busy r9 stalls and does not reload
    bus.lat_issue = 1'b1; bus.lat_rd = 5'd9; bus.lat_cycles = 4'd5;
    tick();
    bus.lat_cycles = 4'd2;
    #1 check_vec("waw_stall", 64'(bus.stall), 64'd1);
    tick();
    bus.lat_issue = 1'b0;
    tick(); tick(); tick();
    check_vec("waw_noreload", 64'(bus.pending_mask), 64'h200);
    tick();
    check_vec("waw_drain", 64'(bus.pending_mask), 64'd0);

    // Ignored issues: lat_rd==0 or lat_cycles==0
    bus.lat_issue = 1'b1; bus.lat_rd = 5'd0; bus.lat_cycles = 4'd3;
    #1 check_vec("ign_r0_stall", 64'(bus.stall), 64'd0);
    tick();
    check_vec("ign_r0_pend", 64'(bus.pending_mask), 64'd0);
    bus.lat_rd = 5'd6; bus.lat_cycles = 4'd0;
    tick();
    check_vec("ign_c0_pend", 64'(bus.pending_mask), 64'd0);

    // Concurrent accept and countdown
    bus.lat_rd = 5'd9; bus.lat_cycles = 4'd2;
    tick();
    bus.lat_rd = 5'd3; bus.lat_cycles = 4'd1;
    tick();
    bus.lat_issue = 1'b0;
    #1 check_vec("conc_pend", 64'(bus.pending_mask), 64'h208);
    tick();
    check_vec("conc_drain", 64'(bus.pending_mask), 64'd0);
    clear_inputs();

    // Reset mid-countdown aborts the scoreboard
    bus.lat_issue = 1'b1; bus.lat_rd = 5'd4; bus.lat_cycles = 4'd15;
    tick();
    bus.lat_issue = 1'b0;
    bus.rs1 = 5'd4; bus.rs1_used = 1'b1;
    #1 check_vec("mid_stall", 64'(bus.stall), 64'd1);
    reset = 1'b0;
    #1 check_vec("mid_rst_pend", 64'(bus.pending_mask), 64'd0);
    check_vec("mid_rst_stall", 64'(bus.stall), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    check_vec("post_rst_pend", 64'(bus.pending_mask), 64'd0);
    check_vec("post_rst_stall", 64'(bus.stall), 64'd0);
    check_vec("post_rst_scount", 64'(bus.stall_count), 64'd0);
    clear_inputs();

    // Six stall edges for the performance counter
    bus.MemRead_EX = 1'b1; bus.rd_EX = 5'd7; bus.rs2 = 5'd7; bus.rs2_used = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    clear_inputs();
    tick();
    check_vec("perf_scount", 64'(bus.stall_count), 64'(EXP_SC));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
